// File: rtl/datapath_control_unit_pkg.sv
// cu_pkg: shared state, class, select-encoding, ALU function and branch condition constants
package cu_pkg;
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [2:0] CL_ALU_REG  = 3'b000;
    localparam logic [2:0] CL_ALU_IMM  = 3'b001;
    localparam logic [2:0] CL_LOAD     = 3'b010;
    localparam logic [2:0] CL_STORE    = 3'b011;
    localparam logic [2:0] CL_BRANCH   = 3'b100;
    localparam logic [2:0] CL_JUMP_REG = 3'b101;
    localparam logic [2:0] CL_NOP      = 3'b110;
    localparam logic [2:0] CL_HALT     = 3'b111;

    localparam logic [2:0] DS_ALU = 3'd0;
    localparam logic [2:0] DS_B   = 3'd1;
    localparam logic [2:0] DS_PC  = 3'd2;
    localparam logic [2:0] DS_MEM = 3'd3;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

    localparam logic AS_PC  = 1'b0;
    localparam logic AS_ALU = 1'b1;

    localparam logic [4:0] FS_ADD = 5'b00010;
    localparam logic [4:0] FS_SUB = 5'b11000;

    localparam logic [3:0] CC_AL = 4'd0;
    localparam logic [3:0] CC_Z  = 4'd1;
    localparam logic [3:0] CC_NZ = 4'd2;
    localparam logic [3:0] CC_N  = 4'd3;
    localparam logic [3:0] CC_NN = 4'd4;
    localparam logic [3:0] CC_C  = 4'd5;
    localparam logic [3:0] CC_V  = 4'd6;
endpackage

// File: rtl/datapath_control_unit_cond_eval.sv
// cu_cond_eval: branch condition evaluation against status flags {V,C,N,Z}
module cu_cond_eval
    import cu_pkg::*;
(
    input  logic [3:0] sf,
    input  logic [3:0] cond,
    output logic       take
);
    always_comb
        take = cond == CC_AL ? 1'b1   :
               cond == CC_Z  ? sf[0]  :
               cond == CC_NZ ? !sf[0] :
               cond == CC_N  ? sf[1]  :
               cond == CC_NN ? !sf[1] :
               cond == CC_C  ? sf[2]  :
               cond == CC_V  ? sf[3]  : 1'b0;
endmodule

// File: rtl/datapath_control_unit.sv
// datapath_control_unit: fetch/decode/execute sequencer for datapath_core
// CU_SINGLE_STEP_EN: FETCH waits for a cycle with step=1 before fetching.
module datapath_control_unit
    import cu_pkg::*;
#(
    parameter int IMM_W = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic [3:0]  sf,
    input  logic        step,
    output logic        as_o,
    output logic [2:0]  ds,
    output logic [1:0]  ps,
    output logic        pc_sel,
    output logic        k_sel,
    output logic        il,
    output logic        sl,
    output logic        mw,
    output logic        rw,
    output logic [4:0]  fs,
    output logic        c0,
    output logic [4:0]  da,
    output logic [4:0]  sa,
    output logic [4:0]  sb,
    output logic [63:0] k,
    output logic [63:0] cu,
    output logic        halted,
    output logic [1:0]  state_o
);
    state_t            state;
    logic              take;
    logic              go;
    logic [2:0]        cls;
    logic [IMM_W-1:0]  imm;

    assign cls = ir[31:29];
    assign imm = ir[IMM_W-1:0];

`ifdef CU_SINGLE_STEP_EN
    assign go = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign go = 1'b1;
`endif

    cu_cond_eval u_cond (
        .sf  (sf),
        .cond(ir[22:19]),
        .take(take)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= ST_FETCH;
        else
            case (state)
                ST_FETCH:   state <= go ? ST_DECODE : ST_FETCH;
                ST_DECODE:  state <= ST_EXECUTE;
                ST_EXECUTE: state <= cls == CL_HALT ? ST_HALT : ST_FETCH;
                default:    state <= ST_HALT;
            endcase

    always_comb begin
        as_o   = AS_PC;
        ds     = DS_ALU;
        ps     = PS_HOLD;
        pc_sel = 1'b0;
        k_sel  = 1'b0;
        il     = 1'b0;
        sl     = 1'b0;
        mw     = 1'b0;
        rw     = 1'b0;
        fs     = '0;
        c0     = 1'b0;
        case (state)
            ST_FETCH: begin
                ds = DS_MEM;
                il = go;
                ps = go ? PS_INC : PS_HOLD;
            end
            ST_EXECUTE:
                case (cls)
                    CL_ALU_REG, CL_ALU_IMM: begin
                        k_sel = cls == CL_ALU_IMM;
                        rw    = 1'b1;
                        sl    = 1'b1;
                        fs    = ir[28:24];
                        c0    = (ir[28:24] & FS_SUB) == FS_SUB;
                    end
                    CL_LOAD: begin
                        fs    = FS_ADD;
                        k_sel = 1'b1;
                        as_o  = AS_ALU;
                        ds    = DS_MEM;
                        rw    = 1'b1;
                    end
                    CL_STORE: begin
                        fs    = FS_ADD;
                        k_sel = 1'b1;
                        as_o  = AS_ALU;
                        ds    = DS_B;
                        mw    = 1'b1;
                    end
                    CL_BRANCH: begin
                        pc_sel = 1'b1;
                        ps     = take ? PS_REL : PS_HOLD;
                    end
                    CL_JUMP_REG: ps = PS_LOAD;
                    default: ;
                endcase
            default: ;
        endcase
        // reset is asynchronous, so gate enables directly to drop in-flight writes
        if (rst) begin
            il = 1'b0;
            sl = 1'b0;
            mw = 1'b0;
            rw = 1'b0;
            ps = PS_HOLD;
        end
    end

    always_comb
        k = cls == CL_BRANCH ? {{(64-IMM_W){imm[IMM_W-1]}}, imm} :
            (cls == CL_ALU_IMM || cls == CL_LOAD || cls == CL_STORE) ? {{(64-IMM_W){1'b0}}, imm} : '0;

    assign da      = ir[23:19];
    assign sa      = ir[18:14];
    assign sb      = ir[13:9];
    assign cu      = '0;
    assign halted  = state == ST_HALT;
    assign state_o = state;
endmodule
